// File: rtl/video_line_doubler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : video_line_doubler_pkg
//  Description : Shared types and helpers for the video line doubler.
//  Revision    : 1.0  initial release
// ============================================================================
package video_line_doubler_pkg;

    // Replay pass of the currently buffered line
    typedef enum logic [0:0] {
        PASS_FIRST  = 1'b0,
        PASS_SECOND = 1'b1
    } pass_e;

    function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/video_line_ram.sv
`default_nettype none
// ============================================================================
//  Module      : video_line_ram
//  Description : Simple dual-port synchronous RAM, one write port, one read
//                port with a registered (1-clk) read.
//  Revision    : 1.0  initial release
// ============================================================================
module video_line_ram #(
    parameter int DATA_W = 5,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    localparam int c_DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [0:c_DEPTH-1];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/video_line_doubler.sv
`default_nettype none
// ============================================================================
//  Module      : video_line_doubler
//  Description : Buffers one input video line and replays it twice at double
//                pixel rate with a regenerated hsync and optional scanlines.
//  Revision    : 1.0  initial release
// ============================================================================
module video_line_doubler
    import video_line_doubler_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MAX_PIX = 1024,
    parameter int IN_DIV  = 2,
    parameter int PER_W   = 12,
    parameter int HSYNC_W = 64
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             line_reset,
    input  logic [WIDTH-1:0] video_in,
    input  logic             de_in,
    input  logic             scanline_en,
    output logic [WIDTH-1:0] dbl_video,
    output logic             dbl_de,
    output logic             dbl_hsync,
    output logic             dbl_second,
    output logic             overflow
);
    localparam int c_ADDR_W = (MAX_PIX > 1) ? $clog2(MAX_PIX) : 1;
    localparam int c_LEN_W  = c_ADDR_W + 1;
    localparam int c_DIV_W  = (IN_DIV > 1) ? $clog2(IN_DIV) : 1;
    localparam int c_SUB_N  = (IN_DIV > 1) ? IN_DIV / 2 : 1;
    localparam int c_SUB_W  = (c_SUB_N > 1) ? $clog2(c_SUB_N) : 1;

    localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(IN_DIV - 1);
    localparam logic [c_DIV_W-1:0]  c_DIV_NEXT  = (IN_DIV > 1) ? c_DIV_W'(1) : c_DIV_W'(0);
    localparam logic [c_SUB_W-1:0]  c_SUB_LAST  = c_SUB_W'(c_SUB_N - 1);
    localparam logic [c_ADDR_W-1:0] c_ADDR_LAST = c_ADDR_W'(MAX_PIX - 1);
    localparam logic [c_LEN_W-1:0]  c_LEN_MAX   = c_LEN_W'(MAX_PIX);
    localparam logic [PER_W-1:0]    c_PER_MAX   = '1;

    // ------------------------------------------------------------------
    // Input side state
    // ------------------------------------------------------------------
    logic [c_DIV_W-1:0]  r_in_div;
    logic                r_wr_bank;
    logic [c_ADDR_W-1:0] r_wr_addr;
    logic                r_wr_full;
    logic                r_overflow;
    logic [PER_W-1:0]    r_period_cnt;
    logic [PER_W-1:0]    r_period_q;
    logic [c_LEN_W-1:0]  r_len_q;
    logic                r_seen_lr;
    logic                r_out_en;

    // ------------------------------------------------------------------
    // Output side state
    // ------------------------------------------------------------------
    logic                r_rd_bank;
    logic [PER_W-1:0]    r_hc;
    logic [c_SUB_W-1:0]  r_sub;
    logic [c_LEN_W-1:0]  r_rd_addr;
    pass_e               r_pass;
    logic                r_de_d;
    logic                r_hsync_d;
    logic                r_second_d;
    logic                r_blank_d;

    logic                w_strobe;
    logic                w_wr_en;
    logic                w_wr_bank;
    logic [c_ADDR_W-1:0] w_wr_addr;
    logic [PER_W-1:0]    w_half;
    logic [PER_W-1:0]    w_hsync_lim;
    logic                w_hc_last;
    logic                w_rd_in_range;
    logic [WIDTH:0]      w_rd_data;

    // The line_reset cycle always carries pixel 0 of the new line into the new bank
    assign w_strobe  = line_reset | (r_in_div == '0);
    assign w_wr_en   = line_reset | (w_strobe & ~r_wr_full);
    assign w_wr_bank = line_reset ? ~r_wr_bank : r_wr_bank;
    assign w_wr_addr = line_reset ? '0 : r_wr_addr;

    assign w_half        = r_period_q >> 1;
    assign w_hsync_lim   = PER_W'(min_u(HSYNC_W, 32'(w_half)));
    assign w_hc_last     = ({1'b0, r_hc} + (PER_W + 1)'(1)) >= {1'b0, w_half};
    assign w_rd_in_range = (r_rd_addr < r_len_q);

    video_line_ram #(
        .DATA_W (WIDTH + 1),
        .ADDR_W (c_ADDR_W + 1)
    ) u_line_ram (
        .clk     (clk),
        .i_we    (w_wr_en),
        .i_waddr ({w_wr_bank, w_wr_addr}),
        .i_wdata ({de_in, video_in}),
        .i_raddr ({r_rd_bank, r_rd_addr[c_ADDR_W-1:0]}),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_in_div     <= '0;
            r_wr_bank    <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_full    <= 1'b0;
            r_overflow   <= 1'b0;
            r_period_cnt <= '0;
            r_period_q   <= '0;
            r_len_q      <= '0;
            r_seen_lr    <= 1'b0;
            r_out_en     <= 1'b0;
        end else begin
            if (line_reset) begin
                r_in_div <= c_DIV_NEXT;
            end else if (r_in_div == c_DIV_LAST) begin
                r_in_div <= '0;
            end else begin
                r_in_div <= r_in_div + c_DIV_W'(1);
            end

            if (line_reset) begin
                r_wr_bank    <= ~r_wr_bank;
                r_wr_addr    <= c_ADDR_W'(1);
                r_wr_full    <= 1'b0;
                r_len_q      <= r_wr_full ? c_LEN_MAX : {1'b0, r_wr_addr};
                r_period_q   <= r_period_cnt;
                r_period_cnt <= PER_W'(1);
                r_seen_lr    <= 1'b1;
                r_out_en     <= r_out_en | r_seen_lr;
            end else begin
                if (r_period_cnt != c_PER_MAX) begin
                    r_period_cnt <= r_period_cnt + PER_W'(1);
                end
                // Last address is held once written; further pixels of this line are dropped
                if (w_strobe) begin
                    if (r_wr_full) begin
                        r_overflow <= 1'b1;
                    end else if (r_wr_addr == c_ADDR_LAST) begin
                        r_wr_full <= 1'b1;
                    end else begin
                        r_wr_addr <= r_wr_addr + c_ADDR_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_rd_bank  <= 1'b0;
            r_hc       <= '0;
            r_sub      <= '0;
            r_rd_addr  <= '0;
            r_pass     <= PASS_FIRST;
            r_de_d     <= 1'b0;
            r_hsync_d  <= 1'b0;
            r_second_d <= 1'b0;
            r_blank_d  <= 1'b0;
        end else begin
            if (line_reset) begin
                r_rd_bank <= r_wr_bank;
                r_hc      <= '0;
                r_sub     <= '0;
                r_rd_addr <= '0;
                r_pass    <= PASS_FIRST;
            end else if (w_hc_last) begin
                r_hc      <= '0;
                r_sub     <= '0;
                r_rd_addr <= '0;
                r_pass    <= PASS_SECOND;
            end else begin
                r_hc <= r_hc + PER_W'(1);
                if (r_sub == c_SUB_LAST) begin
                    r_sub <= '0;
                    if (r_rd_addr != c_LEN_MAX) begin
                        r_rd_addr <= r_rd_addr + c_LEN_W'(1);
                    end
                end else begin
                    r_sub <= r_sub + c_SUB_W'(1);
                end
            end

            // Control delayed one clk to line up with the registered RAM read
            r_de_d     <= r_out_en & w_rd_in_range;
            r_hsync_d  <= r_out_en & (r_hc < w_hsync_lim);
            r_second_d <= r_out_en & (r_pass == PASS_SECOND);
            r_blank_d  <= r_out_en & scanline_en & (r_pass == PASS_SECOND);
        end
    end

    assign dbl_de     = r_de_d & w_rd_data[WIDTH];
    assign dbl_video  = (dbl_de & ~r_blank_d) ? w_rd_data[WIDTH-1:0] : {WIDTH{1'b0}};
    assign dbl_hsync  = r_hsync_d;
    assign dbl_second = r_second_d;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_video_line_doubler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_video_line_doubler
//  Description : Self-checking bench for video_line_doubler (line table with
//                scoreboard, plus overflow and reset sequences).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_video_line_doubler;

    typedef struct {
        int period;
        int n_de;
        bit scan;
        int exp_half;
        int exp_hs;
    } line_vec_t;

    typedef struct {
        bit         chk;
        logic [3:0] video;
        logic       de;
        logic       hs;
        logic       sec;
        int         line;
        int         clk_no;
    } exp_t;

    logic       clk;
    logic       reset_l;
    logic       line_reset;
    logic [3:0] video_in;
    logic       de_in;
    logic       scanline_en;
    logic [3:0] dbl_video;
    logic       dbl_de;
    logic       dbl_hsync;
    logic       dbl_second;
    logic       overflow;

    logic       ov_line_reset;
    logic [3:0] ov_video;
    logic       ov_de;
    logic       ov_scan;
    logic [3:0] ov_dbl_video;
    logic       ov_dbl_de;
    logic       ov_dbl_hsync;
    logic       ov_dbl_second;
    logic       ov_overflow;

    line_vec_t tab [10];
    exp_t      sb_q [$];
    exp_t      mon_e;
    int        n_cmp = 0;
    int        n_bad = 0;

    video_line_doubler dut (
        .clk         (clk),
        .reset_l     (reset_l),
        .line_reset  (line_reset),
        .video_in    (video_in),
        .de_in       (de_in),
        .scanline_en (scanline_en),
        .dbl_video   (dbl_video),
        .dbl_de      (dbl_de),
        .dbl_hsync   (dbl_hsync),
        .dbl_second  (dbl_second),
        .overflow    (overflow)
    );

    video_line_doubler #(.MAX_PIX(64)) dut_ovf (
        .clk         (clk),
        .reset_l     (reset_l),
        .line_reset  (ov_line_reset),
        .video_in    (ov_video),
        .de_in       (ov_de),
        .scanline_en (ov_scan),
        .dbl_video   (ov_dbl_video),
        .dbl_de      (ov_dbl_de),
        .dbl_hsync   (ov_dbl_hsync),
        .dbl_second  (ov_dbl_second),
        .overflow    (ov_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            if (mon_e.chk) begin
                n_cmp = n_cmp + 1;
                if ({dbl_video, dbl_de, dbl_hsync, dbl_second} !==
                    {mon_e.video, mon_e.de, mon_e.hs, mon_e.sec}) begin
                    n_bad = n_bad + 1;
                    $display("FAIL replay line %0d clk %0d: got video=%h de=%b hs=%b sec=%b, expected video=%h de=%b hs=%b sec=%b",
                             mon_e.line, mon_e.clk_no, dbl_video, dbl_de, dbl_hsync, dbl_second,
                             mon_e.video, mon_e.de, mon_e.hs, mon_e.sec);
                end
            end
        end
    end

    task automatic push_idle(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            line_reset  = 1'b0;
            video_in    = 4'h0;
            de_in       = 1'b0;
            scanline_en = 1'b0;
            e = '{chk: 1'b1, video: 4'h0, de: 1'b0, hs: 1'b0, sec: 1'b0, line: -1, clk_no: i};
            sb_q.push_back(e);
            @(negedge clk);
            #1;
        end
    endtask

    // Drive one input line and queue what the DUT must show while it plays
    task automatic run_line(input int li, input int line_no);
        line_vec_t cur;
        line_vec_t prv;
        exp_t      e;
        int        t;
        int        hc;
        int        len;
        bit        sec;
        cur = tab[li];
        prv = tab[(li > 0) ? li - 1 : 0];
        len = (prv.period + 1) / 2;
        for (int k = 0; k < cur.period; k++) begin
            line_reset  = (k == 0);
            video_in    = 4'((k / 2) % 16);
            de_in       = ((k / 2) < cur.n_de);
            scanline_en = cur.scan;
            e = '{chk: 1'b1, video: 4'h0, de: 1'b0, hs: 1'b0, sec: 1'b0, line: line_no, clk_no: k};
            if (line_no == 0 || (line_no == 1 && k == 0)) begin
                e.chk = 1'b1;
            end else if (k == 0) begin
                e.chk = 1'b0;
            end else begin
                t   = k - 1;
                sec = (t >= cur.exp_half);
                hc  = sec ? (t - cur.exp_half) % cur.exp_half : t;
                e.de    = (hc < len) && (hc < prv.n_de);
                e.video = (e.de && !(cur.scan && sec)) ? 4'(hc % 16) : 4'h0;
                e.hs    = (hc < cur.exp_hs);
                e.sec   = sec;
            end
            sb_q.push_back(e);
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        tab[0] = '{228, 80,  1'b0,   0,  0};
        tab[1] = '{228, 80,  1'b0, 114, 64};
        tab[2] = '{228, 40,  1'b0, 114, 64};
        tab[3] = '{228, 80,  1'b1, 114, 64};
        tab[4] = '{150, 20,  1'b0, 114, 64};
        tab[5] = '{228, 80,  1'b1,  75, 64};
        tab[6] = '{100, 80,  1'b0, 114, 64};
        tab[7] = '{400, 30,  1'b0,  50, 50};
        tab[8] = '{228, 80,  1'b0, 200, 64};
        tab[9] = '{228, 80,  1'b0, 114, 64};

        reset_l       = 1'b0;
        line_reset    = 1'b0;
        video_in      = 4'h0;
        de_in         = 1'b0;
        scanline_en   = 1'b0;
        ov_line_reset = 1'b0;
        ov_video      = 4'h0;
        ov_de         = 1'b0;
        ov_scan       = 1'b0;
        repeat (3) @(negedge clk);
        check("reset dbl_outputs", {dbl_video, dbl_de, dbl_hsync, dbl_second}, 32'h0);
        check("reset overflow", overflow, 1'b0);
        #1;
        reset_l = 1'b1;
        @(negedge clk);
        #1;

        // Overflow: 64-pixel buffer fed a 100-pixel line, then shorter lines
        for (int k = 0; k < 200; k++) begin
            ov_line_reset = (k == 0);
            ov_video      = 4'((k / 2) % 16);
            ov_de         = 1'b1;
            @(negedge clk);
            if (k == 127) check("ovf before pixel 64", ov_overflow, 1'b0);
            if (k == 128) check("ovf at pixel 64", ov_overflow, 1'b1);
            #1;
        end
        for (int k = 0; k < 120; k++) begin
            ov_line_reset = (k == 0);
            ov_video      = 4'((k / 2) % 16);
            ov_de         = 1'b1;
            @(negedge clk);
            if (k == 2)   check("ovf replay pix1", {ov_dbl_video, ov_dbl_de, ov_dbl_hsync, ov_dbl_second}, {4'h1, 1'b1, 1'b1, 1'b0});
            if (k == 64)  check("ovf replay pix63", {ov_dbl_video, ov_dbl_de, ov_dbl_hsync, ov_dbl_second}, {4'hf, 1'b1, 1'b1, 1'b0});
            if (k == 65)  check("ovf replay pix64 dropped", {ov_dbl_video, ov_dbl_de, ov_dbl_hsync, ov_dbl_second}, {4'h0, 1'b0, 1'b0, 1'b0});
            if (k == 102) check("ovf replay second pix1", {ov_dbl_video, ov_dbl_de, ov_dbl_hsync, ov_dbl_second}, {4'h1, 1'b1, 1'b1, 1'b1});
            #1;
        end
        for (int k = 0; k < 60; k++) begin
            ov_line_reset = (k == 0);
            ov_video      = 4'((k / 2) % 16);
            ov_de         = 1'b1;
            @(negedge clk);
            #1;
        end
        ov_line_reset = 1'b0;
        check("ovf sticky after short lines", ov_overflow, 1'b1);

        // Main line table through the scoreboard
        push_idle(3);
        for (int i = 0; i < 10; i++) begin
            run_line(i, i);
        end
        check("main overflow stays clear", overflow, 1'b0);

        // Asynchronous reset in the middle of a replay
        reset_l = 1'b0;
        #1;
        check("async reset dbl_outputs", {dbl_video, dbl_de, dbl_hsync, dbl_second}, 32'h0);
        check("async reset overflow", overflow, 1'b0);
        check("async reset ovf overflow", ov_overflow, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        reset_l = 1'b1;
        push_idle(3);
        for (int i = 0; i < 3; i++) begin
            run_line(i, i);
        end
        line_reset = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
